core_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-bit bus path between three cores: N, K and M.
- Its registered one-hot grant output drives the 3-bit select of the 3-to-1 bus mux directly.
- When no core is granted, the grant is 3'b000. The mux output then floats (high-Z) and the bus is released.
- A grant is held until the owning core signals done, drops its request, or (optionally) times out.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_pick3.sv | 35 +++
 rtl/core_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_core_bus_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the three-core round-robin bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [2:0] SEL_N    = 3'b001;
  localparam logic [2:0] SEL_K    = 3'b010;
  localparam logic [2:0] SEL_M    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b000;

  localparam logic [1:0] OWNER_N    = 2'd0;
  localparam logic [1:0] OWNER_K    = 2'd1;
  localparam logic [1:0] OWNER_M    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  function automatic logic [1:0] sel_to_owner(input logic [2:0] sel);
    case (sel)
      SEL_N:   return OWNER_N;
      SEL_K:   return OWNER_K;
      SEL_M:   return OWNER_M;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters, starting after the last owner.
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  output logic [2:0] pick,
  output logic       pick_valid
);

  always_comb begin
    pick = SEL_NONE;
    case (last_owner)
      OWNER_N: begin
        if (req[1])      pick = SEL_K;
        else if (req[2]) pick = SEL_M;
        else if (req[0]) pick = SEL_N;
      end
      OWNER_K: begin
        if (req[2])      pick = SEL_M;
        else if (req[0]) pick = SEL_N;
        else if (req[1]) pick = SEL_K;
      end
      // Last owner M (and the unused code) start the rotation at N.
      default: begin
        if (req[0])      pick = SEL_N;
        else if (req[1]) pick = SEL_K;
        else if (req[2]) pick = SEL_M;
      end
    endcase
  end

  assign pick_valid = |req;

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter driving a registered one-hot 3:1 bus mux select for cores N, K, M.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module core_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout_flag
);

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("CNT_W too narrow for MAX_HOLD");
  end

  arb_state_e state, state_nxt;
  logic [2:0] grant_nxt;
  logic [1:0] owner_nxt;
  logic [1:0] last_owner, last_nxt;
  logic [2:0] pick;
  logic       pick_valid;
  logic       timeout_hit;
  logic       release_hit;

  rr_pick3 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // Masking with the grant itself restricts done/req to the current owner only.
  assign release_hit = (|(done & grant)) | (~|(req & grant)) | timeout_hit;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    last_nxt  = last_owner;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick;
          owner_nxt = sel_to_owner(pick);
          state_nxt = ST_GRANT;
        end else begin
          grant_nxt = SEL_NONE;
          owner_nxt = OWNER_NONE;
        end
      end
      ST_GRANT: begin
        if (release_hit) begin
          grant_nxt = SEL_NONE;
          owner_nxt = OWNER_NONE;
          last_nxt  = owner;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        grant_nxt = SEL_NONE;
        owner_nxt = OWNER_NONE;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt = SEL_NONE;
        owner_nxt = OWNER_NONE;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= SEL_NONE;
      owner      <= OWNER_NONE;
      last_owner <= OWNER_M;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
    end
  end

  assign busy = |grant;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] hold_cnt;
  logic             tflag;

  // Counter is zero on the first grant cycle, so a hit on MAX_HOLD-1 gives MAX_HOLD cycles.
  assign timeout_hit = (state == ST_GRANT) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      tflag    <= 1'b0;
    end else begin
      tflag <= timeout_hit;
      if (state != ST_GRANT)
        hold_cnt <= '0;
      else if (hold_cnt != CNT_MAX)
        hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign timeout_flag = tflag;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter; covers the ARB_TIMEOUT_EN build when defined.
module tb_core_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;

  core_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .owner        (owner),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [1:0] o);
    chk({tag, "_grant"}, {1'b0, grant}, {1'b0, g});
    chk({tag, "_owner"}, {2'b0, owner}, {2'b0, o});
    chk({tag, "_busy"},  {3'b0, busy},  {3'b0, |g});
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    rst  = 1'b1;
    req  = 3'b000;
    done = 3'b000;
    step();
    step();
    chk_out("reset", 3'b000, 2'd3);
    chk("reset_tflag", {3'b0, timeout_flag}, 4'h0);
    rst = 1'b0;
    step();
    chk_out("idle_noreq", 3'b000, 2'd3);

    // Single requester N
    req = 3'b001;
    step();
    chk_out("single_grant", 3'b001, 2'd0);
    step();
    chk_out("single_hold", 3'b001, 2'd0);
    done = 3'b001;
    step();
    done = 3'b000;
    chk_out("single_release", 3'b000, 2'd3);
    step();
    chk_out("single_idle", 3'b000, 2'd3);
    step();
    chk_out("single_regrant", 3'b001, 2'd0);
    req = 3'b000;
    step();
    chk_out("single_drop", 3'b000, 2'd3);
    step();
    step();
    chk_out("single_quiet", 3'b000, 2'd3);

    // Full contention from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("rr%0d_grant", i), rr_seq[i], (i == 3) ? 2'd0 : 2'(i));
      for (int h = 0; h < 3; h++) begin
        step();
        chk($sformatf("rr%0d_hold%0d", i, h), {1'b0, grant}, {1'b0, rr_seq[i]});
      end
      done = grant;
      step();
      done = 3'b000;
      chk($sformatf("rr%0d_gap1", i), {1'b0, grant}, 4'h0);
      step();
      chk($sformatf("rr%0d_gap2", i), {1'b0, grant}, 4'h0);
      step();
    end
    chk_out("rr_next_k", 3'b010, 2'd1);

    // Owner K drops its request; M is next in rotation ahead of N
    req = 3'b101;
    step();
    chk_out("drop_release", 3'b000, 2'd3);
    step();
    step();
    chk_out("drop_m_next", 3'b100, 2'd2);

    // done and req from the owner together: done releases
    done = 3'b100;
    step();
    done = 3'b000;
    chk_out("done_with_req", 3'b000, 2'd3);
    step();
    step();
    chk_out("after_m_n", 3'b001, 2'd0);

    // Non-owner done and req changes are ignored
    done = 3'b100;
    step();
    done = 3'b000;
    chk_out("nonowner_done", 3'b001, 2'd0);
    req = 3'b001;
    step();
    chk_out("nonowner_drop", 3'b001, 2'd0);

    // Async reset in the middle of a K grant
    req = 3'b010;
    step();
    chk_out("to_k_release", 3'b000, 2'd3);
    step();
    done = 3'b010;
    step();
    done = 3'b000;
    chk_out("k_grant", 3'b010, 2'd1);
    rst = 1'b1;
    #1;
    chk_out("async_reset", 3'b000, 2'd3);
    rst = 1'b0;
    req = 3'b000;
    step();
    chk_out("post_reset", 3'b000, 2'd3);

    // N holds forever with K waiting
    req = 3'b011;
    step();
    chk_out("hold_grant", 3'b001, 2'd0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("to_hold%0d", c), {1'b0, grant}, 4'b0001);
      chk($sformatf("to_flag%0d", c), {3'b0, timeout_flag}, 4'h0);
    end
    step();
    chk_out("to_release", 3'b000, 2'd3);
    chk("to_flag_pulse", {3'b0, timeout_flag}, 4'h1);
    step();
    chk("to_flag_clear", {3'b0, timeout_flag}, 4'h0);
    chk("to_gap", {1'b0, grant}, 4'h0);
    step();
    chk_out("to_k_next", 3'b010, 2'd1);
`else
    for (int c = 1; c < 30; c++) begin
      step();
      chk($sformatf("nto_hold%0d", c), {1'b0, grant}, 4'b0001);
      chk($sformatf("nto_flag%0d", c), {3'b0, timeout_flag}, 4'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
